// File: rtl/flow_source.sv
// flow_source: producer-side partner of the lane flow-control FSM.
// Routes a single upstream word stream into four lane FIFOs, one word per
// cycle at most, honouring per-lane pause/resume, the idle start signal and
// the error_full abort. A blocked head word stalls the whole stream.
module flow_source #(
    parameter int DATA_W = 6,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enb,
    input  logic [3:0]        pausa,
    input  logic [3:0]        continuar,
    input  logic              error_full,
    input  logic              idle,
    input  logic              valid_in,
    input  logic [1:0]        dest_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              ready_out,
    output logic [3:0]        push,
    output logic [DATA_W-1:0] data_out,
    output logic [1:0]        state_out,
    output logic [CNT_W-1:0]  sent_count,
    output logic              error_out
);

    typedef enum logic [1:0] {
        stWait   = 2'd0,
        stActive = 2'd1,
        stHalt   = 2'd2
    } stateT;

    stateT      state;
    stateT      stateNext;
    logic [3:0] laneOn;
    logic       xfer;

    // Decode a lane index into the one-hot FIFO write strobe.
    function automatic logic [3:0] oneHot(input logic [1:0] lane);
        logic [3:0] strobe;
        strobe       = 4'b0000;
        strobe[lane] = 1'b1;
        return strobe;
    endfunction

    // Pushed-word counter advances modulo 2^CNT_W.
    function automatic logic [CNT_W-1:0] incWrap(input logic [CNT_W-1:0] count);
        return count + CNT_W'(1);
    endfunction

    // Handshake: a lane being paused this cycle is already blocked.
    always_comb begin
        ready_out = enb & (state == stActive) & ~error_full
                  & laneOn[dest_in] & ~pausa[dest_in];
        xfer      = valid_in & ready_out;
    end

    // Next global state; error_full overrides every other transition.
    always_comb begin
        stateNext = state;
        unique case (state)
            stWait: begin
                if (error_full)
                    stateNext = stHalt;
                else if (idle)
                    stateNext = stActive;
            end
            stActive: begin
                if (error_full)
                    stateNext = stHalt;
            end
            stHalt:  stateNext = stHalt;
            default: stateNext = stHalt;
        endcase
    end

    // Global state register and sticky abort flag, frozen while enb is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= stWait;
            error_out <= 1'b0;
        end else if (enb) begin
            state <= stateNext;
            if (stateNext == stHalt)
                error_out <= 1'b1;
        end
    end

    // Per-lane on/off tracking; pause beats resume when both arrive together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            laneOn <= 4'b1111;
        else if (enb)
            laneOn <= (laneOn | continuar) & ~pausa;
    end

    // Registered FIFO write port; the strobe drops on every non-transfer edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            push       <= 4'b0000;
            data_out   <= '0;
            sent_count <= '0;
        end else begin
            push <= xfer ? oneHot(dest_in) : 4'b0000;
            if (xfer) begin
                data_out   <= data_in;
                sent_count <= incWrap(sent_count);
            end
        end
    end

    assign state_out = state;

endmodule

// File: tb/tb_flow_source.sv
// Directed testbench for flow_source. Inputs change 1 ns after the rising
// edge; outputs are sampled 2 ns after the edge, away from the active edge.
module tb_flow_source;

    localparam int DATA_W = 6;
    localparam int CNT_W  = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              enb = 1'b1;
    logic [3:0]        pausa = '0;
    logic [3:0]        continuar = '0;
    logic              error_full = 1'b0;
    logic              idle = 1'b0;
    logic              valid_in = 1'b0;
    logic [1:0]        dest_in = '0;
    logic [DATA_W-1:0] data_in = '0;
    logic              ready_out;
    logic [3:0]        push;
    logic [DATA_W-1:0] data_out;
    logic [1:0]        state_out;
    logic [CNT_W-1:0]  sent_count;
    logic              error_out;

    int errors = 0;
    int checks = 0;

    flow_source #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .enb(enb), .pausa(pausa), .continuar(continuar),
        .error_full(error_full), .idle(idle), .valid_in(valid_in),
        .dest_in(dest_in), .data_in(data_in), .ready_out(ready_out),
        .push(push), .data_out(data_out), .state_out(state_out),
        .sent_count(sent_count), .error_out(error_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance to 1 ns after the next rising edge (input drive point).
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        enb = 1'b1; pausa = '0; continuar = '0; error_full = 1'b0;
        idle = 1'b0; valid_in = 1'b0; dest_in = '0; data_in = '0;
        pulseReset();
        checks++; if (state_out !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_out); end
        checks++; if (push !== 4'b0000) begin errors++; $display("FAIL reset_push: got %b expected 0000", push); end
        checks++; if (data_out !== 6'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", data_out); end
        checks++; if (sent_count !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", sent_count); end
        checks++; if (error_out !== 1'b0) begin errors++; $display("FAIL reset_error: got %b expected 0", error_out); end
        checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready_out); end
    endtask

    task automatic test_startup();
        valid_in = 1'b1; dest_in = 2'd2; data_in = 6'h15; idle = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL startup_ready_wait: got %b expected 0", ready_out); end
            checks++; if (push !== 4'b0000) begin errors++; $display("FAIL startup_push_wait: got %b expected 0000", push); end
            checks++; if (state_out !== 2'd0) begin errors++; $display("FAIL startup_state_wait: got %0d expected 0", state_out); end
        end
        tick();
        idle = 1'b1;
        tick(); #1;
        checks++; if (state_out !== 2'd1) begin errors++; $display("FAIL startup_state_active: got %0d expected 1", state_out); end
        checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL startup_ready_active: got %b expected 1", ready_out); end
        checks++; if (push !== 4'b0000) begin errors++; $display("FAIL startup_no_early_push: got %b expected 0000", push); end
        tick();
        valid_in = 1'b0; idle = 1'b0;
        #1;
        checks++; if (push !== 4'b0100) begin errors++; $display("FAIL startup_push: got %b expected 0100", push); end
        checks++; if (data_out !== 6'h15) begin errors++; $display("FAIL startup_data: got %h expected 15", data_out); end
        checks++; if (sent_count !== 8'd1) begin errors++; $display("FAIL startup_count: got %0d expected 1", sent_count); end
        tick(); #1;
        checks++; if (push !== 4'b0000) begin errors++; $display("FAIL startup_push_clear: got %b expected 0000", push); end
    endtask

    task automatic test_streaming();
        logic [3:0] expPush [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        valid_in = 1'b1; dest_in = 2'd0; data_in = 6'h01;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i < 3) begin
                dest_in = 2'(i + 1);
                data_in = 6'(i + 2);
            end else begin
                valid_in = 1'b0;
            end
            #1;
            checks++; if (push !== expPush[i]) begin errors++; $display("FAIL stream_push_%0d: got %b expected %b", i, push, expPush[i]); end
            checks++; if (data_out !== 6'(i + 1)) begin errors++; $display("FAIL stream_data_%0d: got %h expected %h", i, data_out, 6'(i + 1)); end
        end
        checks++; if (sent_count !== 8'd5) begin errors++; $display("FAIL stream_count: got %0d expected 5", sent_count); end
        tick(); #1;
        checks++; if (push !== 4'b0000) begin errors++; $display("FAIL stream_push_idle: got %b expected 0000", push); end
        checks++; if (data_out !== 6'h04) begin errors++; $display("FAIL stream_data_hold: got %h expected 04", data_out); end
    endtask

    task automatic test_pause_resume();
        valid_in = 1'b1; dest_in = 2'd1; data_in = 6'h2A; pausa = 4'b0010;
        #1;
        checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL pause_same_cycle: got %b expected 0", ready_out); end
        tick();
        pausa = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL pause_ready_%0d: got %b expected 0", i, ready_out); end
            checks++; if (push !== 4'b0000) begin errors++; $display("FAIL pause_push_%0d: got %b expected 0000", i, push); end
            tick();
        end
        checks++; if (sent_count !== 8'd5) begin errors++; $display("FAIL pause_count: got %0d expected 5", sent_count); end
        continuar = 4'b0010;
        tick();
        continuar = 4'b0000;
        #1;
        checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL resume_ready: got %b expected 1", ready_out); end
        tick();
        dest_in = 2'd0; data_in = 6'h0B;
        #1;
        checks++; if (push !== 4'b0010) begin errors++; $display("FAIL resume_push: got %b expected 0010", push); end
        checks++; if (data_out !== 6'h2A) begin errors++; $display("FAIL resume_data: got %h expected 2a", data_out); end
        checks++; if (sent_count !== 8'd6) begin errors++; $display("FAIL resume_count: got %0d expected 6", sent_count); end
        tick();
        valid_in = 1'b0;
        #1;
        checks++; if (push !== 4'b0001) begin errors++; $display("FAIL queued_push: got %b expected 0001", push); end
        checks++; if (data_out !== 6'h0B) begin errors++; $display("FAIL queued_data: got %h expected 0b", data_out); end
        checks++; if (sent_count !== 8'd7) begin errors++; $display("FAIL queued_count: got %0d expected 7", sent_count); end
        pausa = 4'b1000; continuar = 4'b1000;
        tick();
        pausa = 4'b0000; continuar = 4'b0000;
        valid_in = 1'b1; dest_in = 2'd3; data_in = 6'h11;
        #1;
        checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL both_pause_wins: got %b expected 0", ready_out); end
        valid_in = 1'b0;
        continuar = 4'b1000;
        tick();
        continuar = 4'b0000;
        tick();
    endtask

    task automatic test_abort();
        valid_in = 1'b1; dest_in = 2'd0; data_in = 6'h33; error_full = 1'b1;
        #1;
        checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL abort_ready: got %b expected 0", ready_out); end
        tick();
        error_full = 1'b0;
        #1;
        checks++; if (push !== 4'b0000) begin errors++; $display("FAIL abort_push: got %b expected 0000", push); end
        checks++; if (state_out !== 2'd2) begin errors++; $display("FAIL abort_state: got %0d expected 2", state_out); end
        checks++; if (error_out !== 1'b1) begin errors++; $display("FAIL abort_error: got %b expected 1", error_out); end
        checks++; if (sent_count !== 8'd7) begin errors++; $display("FAIL abort_count: got %0d expected 7", sent_count); end
        continuar = 4'b1111; idle = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(); #1;
            checks++; if (push !== 4'b0000 || ready_out !== 1'b0 || state_out !== 2'd2) begin
                errors++; $display("FAIL halt_hold_%0d: got push=%b ready=%b state=%0d expected 0000/0/2", i, push, ready_out, state_out);
            end
        end
        continuar = 4'b0000; idle = 1'b0; valid_in = 1'b0;
        pulseReset();
        checks++; if (state_out !== 2'd0) begin errors++; $display("FAIL abort_reset_state: got %0d expected 0", state_out); end
        checks++; if (error_out !== 1'b0) begin errors++; $display("FAIL abort_reset_error: got %b expected 0", error_out); end
        checks++; if (sent_count !== 8'd0) begin errors++; $display("FAIL abort_reset_count: got %0d expected 0", sent_count); end
    endtask

    task automatic test_freeze_wrap();
        idle = 1'b1;
        tick();
        idle = 1'b0;
        valid_in = 1'b1;
        for (int i = 0; i < 255; i++) begin
            dest_in = 2'(i);
            data_in = 6'(i);
            tick();
        end
        #1;
        checks++; if (sent_count !== 8'd255) begin errors++; $display("FAIL wrap_pre_count: got %0d expected 255", sent_count); end
        enb = 1'b0; dest_in = 2'd0; data_in = 6'h3F; pausa = 4'b0001;
        #1;
        checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL freeze_ready: got %b expected 0", ready_out); end
        tick();
        pausa = 4'b0000;
        #1;
        checks++; if (push !== 4'b0000) begin errors++; $display("FAIL freeze_push_1: got %b expected 0000", push); end
        checks++; if (sent_count !== 8'd255) begin errors++; $display("FAIL freeze_count_1: got %0d expected 255", sent_count); end
        checks++; if (state_out !== 2'd1) begin errors++; $display("FAIL freeze_state: got %0d expected 1", state_out); end
        tick(); #1;
        checks++; if (push !== 4'b0000) begin errors++; $display("FAIL freeze_push_2: got %b expected 0000", push); end
        checks++; if (sent_count !== 8'd255) begin errors++; $display("FAIL freeze_count_2: got %0d expected 255", sent_count); end
        enb = 1'b1;
        #1;
        checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL freeze_pausa_ignored: got %b expected 1", ready_out); end
        tick();
        valid_in = 1'b0;
        #1;
        checks++; if (push !== 4'b0001) begin errors++; $display("FAIL wrap_push: got %b expected 0001", push); end
        checks++; if (data_out !== 6'h3F) begin errors++; $display("FAIL wrap_data: got %h expected 3f", data_out); end
        checks++; if (sent_count !== 8'd0) begin errors++; $display("FAIL wrap_count: got %0d expected 0", sent_count); end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_streaming();
        test_pause_resume();
        test_abort();
        test_freeze_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
